// File: rtl/crc_pkg.sv
// Shared types, limits and constants for the streaming CRC engine.
// Also hosts the bit-reflection helper used by the engine datapath.
package crc_pkg;

  localparam int CRC_W_MIN = 8;
  localparam int CRC_W_MAX = 32;
  localparam int DATA_W_MIN = 8;
  localparam int DATA_W_MAX = 32;

  localparam logic [31:0] CRC8_POLY        = 32'h0000_0007;
  localparam logic [31:0] CRC16_CCITT_POLY = 32'h0000_1021;
  localparam logic [31:0] CRC32_POLY       = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT       = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOROUT     = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_RESULT = 2'd2
  } state_e;

  // Reverse the low w bits of v; bits at and above w come back zero.
  function automatic logic [31:0] reflect_bits(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] r;
    logic [4:0]  src;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        src = 5'(w - 1 - i);
        r[5'(i)] = v[src];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_stream_engine_if.sv
// Beat stream in and CRC result out, both valid/ready.
// The master drives beats and consumes results; the slave is the engine.
interface crc_stream_engine_if #(
  parameter int CRC_WIDTH  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BCNT_W     = $clog2(DATA_WIDTH/8) + 1
);

  logic                  s_valid_i;
  logic                  s_ready_o;
  logic [DATA_WIDTH-1:0] s_data_i;
  logic                  s_last_i;
  logic [BCNT_W-1:0]     s_bytes_i;
  logic                  crc_valid_o;
  logic                  crc_ready_i;
  logic [CRC_WIDTH-1:0]  crc_o;

  modport master (
    output s_valid_i, s_data_i, s_last_i, s_bytes_i, crc_ready_i,
    input  s_ready_o, crc_valid_o, crc_o
  );

  modport slave (
    input  s_valid_i, s_data_i, s_last_i, s_bytes_i, crc_ready_i,
    output s_ready_o, crc_valid_o, crc_o
  );

endinterface

// File: rtl/crc_byte_step.sv
// Folds one byte, MSB first, into a CRC register with a runtime polynomial.
// Purely combinational: eight unrolled shift/xor steps.
module crc_byte_step #(
  parameter int CRC_WIDTH = 32
) (
  input  logic [CRC_WIDTH-1:0] crc_i,
  input  logic [CRC_WIDTH-1:0] poly_i,
  input  logic [7:0]           data_i,
  output logic [CRC_WIDTH-1:0] crc_o
);

  logic [CRC_WIDTH-1:0] c;
  logic                 fb;

  always_comb begin
    c  = crc_i;
    fb = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      fb = c[CRC_WIDTH-1] ^ data_i[k];
      c  = {c[CRC_WIDTH-2:0], 1'b0};
      if (fb) c = c ^ poly_i;
    end
    crc_o = c;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Runtime-configurable streaming CRC: one byte per cycle from a beat
// buffer, config latched at frame start, finalised result held until taken.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int CRC_WIDTH  = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clr_i,
  input  logic [CRC_WIDTH-1:0] cfg_poly_i,
  input  logic [CRC_WIDTH-1:0] cfg_init_i,
  input  logic [CRC_WIDTH-1:0] cfg_xorout_i,
  input  logic                 cfg_refin_i,
  input  logic                 cfg_refout_i,
  crc_stream_engine_if.slave   bus,
  output logic                 busy_o
);

  localparam int BCNT_W = $clog2(DATA_WIDTH/8) + 1;
  localparam logic [BCNT_W-1:0] NB = BCNT_W'(DATA_WIDTH/8);

  state_e                state_q, state_d;
  logic                  sof_q, sof_d;
  logic [CRC_WIDTH-1:0]  crc_q, crc_d;
  logic [CRC_WIDTH-1:0]  res_q, res_d;
  logic [DATA_WIDTH-1:0] beat_q, beat_d;
  logic                  last_q, last_d;
  logic [BCNT_W-1:0]     nbytes_q, nbytes_d;
  logic [BCNT_W-1:0]     idx_q, idx_d;
  logic [CRC_WIDTH-1:0]  poly_q, poly_d;
  logic [CRC_WIDTH-1:0]  xorout_q, xorout_d;
  logic                  refin_q, refin_d;
  logic                  refout_q, refout_d;

  logic                  st_idle, st_calc, st_result;
  logic                  accept, last_byte;
  logic [BCNT_W-1:0]     bytes_eff;
  logic [DATA_WIDTH-1:0] beat_sh;
  logic [7:0]            raw_byte, din;
  logic [CRC_WIDTH-1:0]  crc_next, crc_fin;
  logic [31:0]           crc_rev;

  assign st_idle   = (state_q == ST_IDLE);
  assign st_calc   = (state_q == ST_CALC);
  assign st_result = (state_q == ST_RESULT);

  assign accept    = bus.s_valid_i & st_idle & ~clr_i;
  assign last_byte = (idx_q == nbytes_q - 1'b1);

  // Short last beats carry only their low bytes; 0 or oversize means full.
  assign bytes_eff = (!bus.s_last_i || bus.s_bytes_i == '0 || bus.s_bytes_i > NB)
                   ? NB : bus.s_bytes_i;

  assign beat_sh  = beat_q >> {idx_q, 3'b000};
  assign raw_byte = beat_sh[7:0];
  assign din      = refin_q ? 8'(reflect_bits(32'(raw_byte), 8)) : raw_byte;

  crc_byte_step #(
    .CRC_WIDTH (CRC_WIDTH)
  ) u_step (
    .crc_i  (crc_q),
    .poly_i (poly_q),
    .data_i (din),
    .crc_o  (crc_next)
  );

  assign crc_rev = reflect_bits(32'(crc_next), CRC_WIDTH);
  assign crc_fin = (refout_q ? CRC_WIDTH'(crc_rev) : crc_next) ^ xorout_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (1'b1)
        st_idle:   if (accept) state_d = ST_CALC;
        st_calc:   if (last_byte) state_d = last_q ? ST_RESULT : ST_IDLE;
        st_result: if (bus.crc_ready_i) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sof_d    = sof_q;
    crc_d    = crc_q;
    res_d    = res_q;
    beat_d   = beat_q;
    last_d   = last_q;
    nbytes_d = nbytes_q;
    idx_d    = idx_q;
    poly_d   = poly_q;
    xorout_d = xorout_q;
    refin_d  = refin_q;
    refout_d = refout_q;
    if (clr_i) begin
      sof_d = 1'b1;
      crc_d = '0;
    end else begin
      unique case (1'b1)
        st_idle: begin
          if (accept) begin
            beat_d   = bus.s_data_i;
            last_d   = bus.s_last_i;
            nbytes_d = bytes_eff;
            idx_d    = '0;
            if (sof_q) begin
              crc_d    = cfg_init_i;
              poly_d   = cfg_poly_i;
              xorout_d = cfg_xorout_i;
              refin_d  = cfg_refin_i;
              refout_d = cfg_refout_i;
              sof_d    = 1'b0;
            end
          end
        end
        st_calc: begin
          crc_d = crc_next;
          idx_d = idx_q + 1'b1;
          if (last_byte && last_q) res_d = crc_fin;
        end
        st_result: begin
          if (bus.crc_ready_i) sof_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sof_q    <= 1'b1;
      crc_q    <= '0;
      res_q    <= '0;
      beat_q   <= '0;
      last_q   <= 1'b0;
      nbytes_q <= '0;
      idx_q    <= '0;
      poly_q   <= '0;
      xorout_q <= '0;
      refin_q  <= 1'b0;
      refout_q <= 1'b0;
    end else begin
      sof_q    <= sof_d;
      crc_q    <= crc_d;
      res_q    <= res_d;
      beat_q   <= beat_d;
      last_q   <= last_d;
      nbytes_q <= nbytes_d;
      idx_q    <= idx_d;
      poly_q   <= poly_d;
      xorout_q <= xorout_d;
      refin_q  <= refin_d;
      refout_q <= refout_d;
    end
  end

  assign bus.s_ready_o   = st_idle;
  assign bus.crc_valid_o = st_result;
  assign bus.crc_o       = res_q;
  assign busy_o          = ~st_idle | ~sof_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine: CRC-8 and CRC-16 byte-wide instances run in
// lockstep, plus a 32-bit-beat CRC-32 instance, against a bit-serial model.
module tb_crc_stream_engine;
  import crc_pkg::*;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        clr32, clr_s;
  logic [31:0] poly32, init32, xo32;
  logic        refin32, refout32;
  logic [7:0]  poly8, init8, xo8;
  logic        refin8, refout8;
  logic [15:0] poly16, init16, xo16;
  logic        refin16, refout16;
  logic        busy32, busy8, busy16;

  int tests = 0;
  int fails = 0;

  crc_stream_engine_if #(.CRC_WIDTH(32), .DATA_WIDTH(32)) if32 ();
  crc_stream_engine_if #(.CRC_WIDTH(8),  .DATA_WIDTH(8))  if8 ();
  crc_stream_engine_if #(.CRC_WIDTH(16), .DATA_WIDTH(8))  if16 ();

  crc_stream_engine #(.CRC_WIDTH(32), .DATA_WIDTH(32)) u32 (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr32),
    .cfg_poly_i(poly32), .cfg_init_i(init32), .cfg_xorout_i(xo32),
    .cfg_refin_i(refin32), .cfg_refout_i(refout32),
    .bus(if32.slave), .busy_o(busy32)
  );

  crc_stream_engine #(.CRC_WIDTH(8), .DATA_WIDTH(8)) u8 (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr_s),
    .cfg_poly_i(poly8), .cfg_init_i(init8), .cfg_xorout_i(xo8),
    .cfg_refin_i(refin8), .cfg_refout_i(refout8),
    .bus(if8.slave), .busy_o(busy8)
  );

  crc_stream_engine #(.CRC_WIDTH(16), .DATA_WIDTH(8)) u16 (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr_s),
    .cfg_poly_i(poly16), .cfg_init_i(init16), .cfg_xorout_i(xo16),
    .cfg_refin_i(refin16), .cfg_refout_i(refout16),
    .bus(if16.slave), .busy_o(busy16)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Message seen as one long bit string divided by the generator polynomial.
  function automatic logic [31:0] ref_crc(input int w, input logic [31:0] poly,
      input logic [31:0] init, input logic [31:0] xo, input bit ri,
      input bit ro, input bq_t msg);
    logic [31:0] mask, r, o;
    bit          top;
    bit          bits[$];
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    foreach (msg[i])
      for (int k = 0; k < 8; k++)
        bits.push_back(ri ? msg[i][k] : msg[i][7-k]);
    r = init & mask;
    foreach (bits[j]) begin
      top = r[w-1] ^ bits[j];
      r   = (r << 1) & mask;
      if (top) r = r ^ (poly & mask);
    end
    o = '0;
    if (ro) begin
      for (int i = 0; i < w; i++) o[i] = r[w-1-i];
    end else begin
      o = r;
    end
    return (o ^ xo) & mask;
  endfunction

  task automatic wait_ready32();
    int n = 0;
    while (!if32.s_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rdy32_wait", if32.s_ready_o, 1);
  endtask

  task automatic send32(input logic [31:0] d, input bit last,
                        input logic [2:0] sb, output int low);
    wait_ready32();
    if32.s_valid_i = 1'b1;
    if32.s_data_i  = d;
    if32.s_last_i  = last;
    if32.s_bytes_i = sb;
    @(negedge clk);
    if32.s_valid_i = 1'b0;
    low = 0;
    while (!if32.s_ready_o && !if32.crc_valid_o && low < 200) begin
      low++;
      @(negedge clk);
    end
  endtask

  task automatic get32(input logic [31:0] exp, input string tag,
                       input int hold);
    int          n = 0;
    logic [31:0] held;
    while (!if32.crc_valid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_vld"}, 32'(if32.crc_valid_o), 1);
    check({tag, "_crc"}, if32.crc_o, exp);
    held = if32.crc_o;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      check({tag, "_hold"},
            {if32.crc_valid_o, if32.s_ready_o, if32.crc_o == held}, 3'b101);
    end
    if32.crc_ready_i = 1'b1;
    @(negedge clk);
    if32.crc_ready_i = 1'b0;
    check({tag, "_idle"}, {if32.s_ready_o, if32.crc_valid_o}, 2'b10);
  endtask

  task automatic frame32(input bq_t msg, input logic [31:0] exp,
                         input string tag, input int hold, input bit scramble);
    int          n, low, rem, nbv;
    logic [31:0] d, sp, si;
    logic [2:0]  sb;
    bit          last, sr;
    n  = msg.size();
    sp = poly32;
    si = init32;
    sr = refin32;
    for (int i = 0; i < n; i += 4) begin
      rem  = n - i;
      nbv  = (rem > 4) ? 4 : rem;
      last = (rem <= 4);
      d    = $urandom;
      for (int k = 0; k < 4; k++)
        if (i + k < n) d[8*k +: 8] = msg[i+k];
      if (!last) begin
        sb = 3'($urandom_range(0, 7));
      end else if (nbv == 4) begin
        sb = 3'($urandom_range(3, 7));
        if (sb == 3'd3) sb = 3'd0;
      end else begin
        sb = 3'(nbv);
      end
      send32(d, last, sb, low);
      check({tag, "_lat"}, low, nbv);
      if (!last) check({tag, "_busy"}, 32'(busy32), 1);
      if (scramble && i == 0) begin
        poly32  = $urandom;
        init32  = $urandom;
        refin32 = ~refin32;
      end
    end
    poly32  = sp;
    init32  = si;
    refin32 = sr;
    get32(exp, tag, hold);
  endtask

  task automatic send_s(input logic [7:0] d, input bit last);
    int n = 0;
    while (!(if8.s_ready_o && if16.s_ready_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rdy_s_wait", {if8.s_ready_o, if16.s_ready_o}, 2'b11);
    if8.s_valid_i  = 1'b1;
    if16.s_valid_i = 1'b1;
    if8.s_data_i   = d;
    if16.s_data_i  = d;
    if8.s_last_i   = last;
    if16.s_last_i  = last;
    if8.s_bytes_i  = 1'($urandom_range(0, 1));
    if16.s_bytes_i = 1'($urandom_range(0, 1));
    @(negedge clk);
    if8.s_valid_i  = 1'b0;
    if16.s_valid_i = 1'b0;
  endtask

  task automatic frame_s(input bq_t msg, input logic [7:0] e8,
                         input logic [15:0] e16, input string tag);
    int n = 0;
    foreach (msg[i]) send_s(msg[i], i == msg.size() - 1);
    while (!(if8.crc_valid_o && if16.crc_valid_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_crc8"}, 32'(if8.crc_o), 32'(e8));
    check({tag, "_crc16"}, 32'(if16.crc_o), 32'(e16));
    if8.crc_ready_i  = 1'b1;
    if16.crc_ready_i = 1'b1;
    @(negedge clk);
    if8.crc_ready_i  = 1'b0;
    if16.crc_ready_i = 1'b0;
  endtask

  initial begin
    bq_t         digits, zero, msg;
    logic [31:0] d, exp;
    int          low, len;

    digits = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    zero   = '{8'h00};

    rst_n = 1'b1;
    clr32 = 1'b0;
    clr_s = 1'b0;
    {if32.s_valid_i, if32.s_last_i, if32.crc_ready_i} = '0;
    {if8.s_valid_i, if8.s_last_i, if8.crc_ready_i}    = '0;
    {if16.s_valid_i, if16.s_last_i, if16.crc_ready_i} = '0;
    if32.s_data_i = '0; if32.s_bytes_i = '0;
    if8.s_data_i  = '0; if8.s_bytes_i  = '0;
    if16.s_data_i = '0; if16.s_bytes_i = '0;
    poly32 = CRC32_POLY; init32 = CRC32_INIT; xo32 = CRC32_XOROUT;
    refin32 = 1'b1; refout32 = 1'b1;
    poly8 = 8'h07; init8 = 8'h00; xo8 = 8'h00; refin8 = 1'b0; refout8 = 1'b0;
    poly16 = 16'h1021; init16 = 16'hFFFF; xo16 = 16'h0000;
    refin16 = 1'b0; refout16 = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    check("rst_crc32", if32.crc_o, 0);
    check("rst_vld_busy", {if32.crc_valid_o, busy32, if8.crc_valid_o, busy8}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {if32.s_ready_o, if8.s_ready_o, if16.s_ready_o}, 3'b111);

    frame_s(digits, 8'hF4, 16'h29B1, "check_9b");
    frame_s(digits, 8'hF4, 16'h29B1, "b2b_9b");
    frame_s(zero, 8'h00,
            16'(ref_crc(16, 32'h1021, 32'hFFFF, 0, 1'b0, 1'b0, zero)), "zero");

    for (int f = 0; f < 6; f++) begin
      poly8  = 8'($urandom);  init8  = 8'($urandom);  xo8  = 8'($urandom);
      poly16 = 16'($urandom); init16 = 16'($urandom); xo16 = 16'($urandom);
      refin8  = 1'($urandom_range(0, 1)); refout8  = 1'($urandom_range(0, 1));
      refin16 = 1'($urandom_range(0, 1)); refout16 = 1'($urandom_range(0, 1));
      msg = {};
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      frame_s(msg,
              8'(ref_crc(8, 32'(poly8), 32'(init8), 32'(xo8),
                         refin8, refout8, msg)),
              16'(ref_crc(16, 32'(poly16), 32'(init16), 32'(xo16),
                          refin16, refout16, msg)),
              "rand_s");
    end

    frame32(digits, 32'hCBF4_3926, "crc32", 5, 1'b0);

    send32(32'h3433_3231, 1'b0, 3'd4, low);
    wait_ready32();
    if32.s_valid_i = 1'b1;
    if32.s_data_i  = 32'h3837_3635;
    if32.s_last_i  = 1'b0;
    @(negedge clk);
    if32.s_valid_i = 1'b0;
    clr32 = 1'b1;
    @(negedge clk);
    clr32 = 1'b0;
    check("clr_state", {if32.s_ready_o, if32.crc_valid_o, busy32}, 3'b100);
    check("clr_crc_kept", if32.crc_o, 32'hCBF4_3926);
    frame32(digits, 32'hCBF4_3926, "after_clr", 0, 1'b0);

    frame32(digits, 32'hCBF4_3926, "cfg_mid", 0, 1'b1);

    wait_ready32();
    if32.s_valid_i = 1'b1;
    if32.s_data_i  = 32'h3433_3231;
    if32.s_last_i  = 1'b0;
    @(negedge clk);
    if32.s_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_outs", {if32.crc_valid_o, busy32, if32.s_ready_o}, 3'b001);
    check("arst_crc", if32.crc_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_ready", {if32.s_ready_o, busy32}, 2'b10);
    frame32(digits, 32'hCBF4_3926, "after_rst", 0, 1'b0);

    for (int f = 0; f < 15; f++) begin
      poly32   = $urandom;
      init32   = $urandom;
      xo32     = $urandom;
      refin32  = 1'($urandom_range(0, 1));
      refout32 = 1'($urandom_range(0, 1));
      msg = {};
      len = $urandom_range(1, 13);
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      exp = ref_crc(32, poly32, init32, xo32, refin32, refout32, msg);
      frame32(msg, exp, "rand32", f % 3, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
